// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 bus sequencer: FSM state codes, LCD pin map,
// power-on init ROM and small helper functions.
package lcd_pkg;

  localparam logic [5:0] S_POR   = 6'd0;
  localparam logic [5:0] S_LOAD  = 6'd1;
  localparam logic [5:0] S_SETUP = 6'd2;
  localparam logic [5:0] S_EHI   = 6'd3;
  localparam logic [5:0] S_WAIT  = 6'd4;
  localparam logic [5:0] S_IDLE  = 6'd5;

  localparam int PIN_RS     = 14;
  localparam int PIN_RW     = 13;
  localparam int PIN_E      = 12;
  localparam int PIN_DB_LSB = 4;

  // 8-bit 2-line, 8-bit 2-line, 8-bit 2-line, display on, clear, entry increment
  localparam int INIT_LEN = 6;
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM =
    {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38};

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    logic [7:0] b;
    if (idx < 3'(INIT_LEN)) begin
      b = INIT_ROM[idx];
    end else begin
      b = 8'h00;
    end
    return b;
  endfunction

  // Clear and return-home need the long busy wait; everything else is short.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] db);
    return !rs && ((db == 8'h01) || (db == 8'h02) || (db == 8'h03));
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_bus_sequencer_if.sv
// Requester handshake plus the LCD pin and debug outputs of the bus sequencer.
interface lcd_bus_sequencer_if;
  logic        req_valid;
  logic        req_rs;
  logic [7:0]  req_data;
  logic        req_ready;
  logic        init_done;
  logic [14:4] pin;
  logic [5:0]  state;

  modport master (
    output req_valid, req_rs, req_data,
    input  req_ready, init_done, pin, state
  );

  modport slave (
    input  req_valid, req_rs, req_data,
    output req_ready, init_done, pin, state
  );
endinterface

// File: rtl/lcd_delay_timer.sv
// Single down-counter shared by every timed phase of the sequencer; it stops at zero
// until reloaded. RESET_VALUE lets the power-on wait start counting straight out of reset.
module lcd_delay_timer #(
  parameter int             W           = 20,
  parameter logic [W-1:0]   RESET_VALUE = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Reload has priority; otherwise count down and hold at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= RESET_VALUE;
    end else if (load) begin
      count_r <= value;
    end else if (count_r != {W{1'b0}}) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {W{1'b0}});

endmodule

// File: rtl/lcd_bus_sequencer.sv
// Sole master of the HD44780 LCD bus: runs the power-on init ROM, then writes
// requester bytes with timed RS/DB setup, E strobe and busy wait.
module lcd_bus_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned POR_WAIT_CYC  = 750000,
  parameter int unsigned SETUP_CYC     = 3,
  parameter int unsigned E_PULSE_CYC   = 12,
  parameter int unsigned CMD_WAIT_CYC  = 2000,
  parameter int unsigned LONG_WAIT_CYC = 82000
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  lcd_bus_sequencer_if.slave bus
);

  localparam int unsigned MAX_CYC = max_u(max_u(max_u(POR_WAIT_CYC, SETUP_CYC),
                                                max_u(E_PULSE_CYC, CMD_WAIT_CYC)),
                                          LONG_WAIT_CYC);
  localparam int TW = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] POR_LD   = TW'(POR_WAIT_CYC);
  localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC);
  localparam logic [TW-1:0] EPW_LD   = TW'(E_PULSE_CYC);
  localparam logic [TW-1:0] CMD_LD   = TW'(CMD_WAIT_CYC);
  localparam logic [TW-1:0] LONG_LD  = TW'(LONG_WAIT_CYC);
  localparam logic [TW-1:0] ONE_CNT  = TW'(1);
  localparam logic [2:0]    INIT_LAST = 3'(INIT_LEN - 1);

  logic [5:0]    state_r, state_s;
  logic [2:0]    init_idx_r, init_idx_s;
  logic          init_done_r, init_done_s;
  logic          cap_rs_r, cap_rs_s;
  logic [7:0]    cap_data_r, cap_data_s;
  logic [14:4]   pin_r, pin_s;
  logic          timer_load_s;
  logic [TW-1:0] timer_value_s;
  logic [TW-1:0] timer_count_s;
  logic          timer_zero_s;

  lcd_delay_timer #(
    .W           (TW),
    .RESET_VALUE (POR_LD)
  ) u_timer (
    .clk   (SYS_clk),
    .rst   (SYS_reset),
    .load  (timer_load_s),
    .value (timer_value_s),
    .count (timer_count_s),
    .zero  (timer_zero_s)
  );

  // Next-state, pin and timer-load decode for the write sequencer.
  always_comb begin
    state_s       = state_r;
    init_idx_s    = init_idx_r;
    init_done_s   = init_done_r;
    cap_rs_s      = cap_rs_r;
    cap_data_s    = cap_data_r;
    pin_s         = pin_r;
    timer_load_s  = 1'b0;
    timer_value_s = {TW{1'b0}};

    case (state_r)
      S_POR: begin
        if (timer_zero_s) begin
          init_idx_s = 3'd0;
          state_s    = S_LOAD;
        end else begin
          state_s = S_POR;
        end
      end
      S_LOAD: begin
        if (!init_done_r) begin
          pin_s[PIN_RS]            = 1'b0;
          pin_s[PIN_DB_LSB +: 8]   = init_byte(init_idx_r);
        end else begin
          pin_s[PIN_RS]            = cap_rs_r;
          pin_s[PIN_DB_LSB +: 8]   = cap_data_r;
        end
        pin_s[PIN_RW]  = 1'b0;
        pin_s[PIN_E]   = 1'b0;
        timer_load_s   = 1'b1;
        timer_value_s  = SETUP_LD;
        state_s        = S_SETUP;
      end
      S_SETUP: begin
        if (timer_zero_s) begin
          pin_s[PIN_E]  = 1'b1;
          timer_load_s  = 1'b1;
          timer_value_s = EPW_LD;
          state_s       = S_EHI;
        end else begin
          state_s = S_SETUP;
        end
      end
      S_EHI: begin
        // E drops one cycle before leaving S_EHI so it is high for exactly E_PULSE_CYC.
        if (timer_zero_s) begin
          pin_s[PIN_E]  = 1'b0;
          timer_load_s  = 1'b1;
          timer_value_s = is_long_cmd(pin_r[PIN_RS], pin_r[PIN_DB_LSB +: 8]) ? LONG_LD : CMD_LD;
          state_s       = S_WAIT;
        end else if (timer_count_s == ONE_CNT) begin
          pin_s[PIN_E] = 1'b0;
        end else begin
          state_s = S_EHI;
        end
      end
      S_WAIT: begin
        if (!timer_zero_s) begin
          state_s = S_WAIT;
        end else if (init_done_r) begin
          state_s = S_IDLE;
        end else if (init_idx_r < INIT_LAST) begin
          init_idx_s = init_idx_r + 3'd1;
          state_s    = S_LOAD;
        end else begin
          init_done_s = 1'b1;
          state_s     = S_IDLE;
        end
      end
      S_IDLE: begin
        if (bus.req_valid) begin
          cap_rs_s   = bus.req_rs;
          cap_data_s = bus.req_data;
          state_s    = S_LOAD;
        end else begin
          state_s = S_IDLE;
        end
      end
      default: begin
        pin_s   = 11'h000;
        state_s = S_POR;
      end
    endcase
  end

  // State, init progress, capture and pin registers; reset drops E immediately.
  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_r     <= S_POR;
      init_idx_r  <= 3'd0;
      init_done_r <= 1'b0;
      cap_rs_r    <= 1'b0;
      cap_data_r  <= 8'h00;
      pin_r       <= 11'h000;
    end else begin
      state_r     <= state_s;
      init_idx_r  <= init_idx_s;
      init_done_r <= init_done_s;
      cap_rs_r    <= cap_rs_s;
      cap_data_r  <= cap_data_s;
      pin_r       <= pin_s;
    end
  end

  assign bus.req_ready = (state_r == S_IDLE);
  assign bus.init_done = init_done_r;
  assign bus.pin       = pin_r;
  assign bus.state     = state_r;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Randomized self-checking bench for lcd_bus_sequencer: a pin monitor extracts E pulses
// and a timing model derived from the write rules predicts each write's latency.
module tb_lcd_bus_sequencer;

  localparam int POR   = 20;
  localparam int SET   = 2;
  localparam int EPW   = 4;
  localparam int CMDW  = 10;
  localparam int LONGW = 50;

  typedef struct {
    logic       rs;
    logic [7:0] db;
    int         width;
    int         rise;
    bit         ok;
  } pulse_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_sent = 0;

  lcd_bus_sequencer_if bus();

  lcd_bus_sequencer #(
    .POR_WAIT_CYC  (POR),
    .SETUP_CYC     (SET),
    .E_PULSE_CYC   (EPW),
    .CMD_WAIT_CYC  (CMDW),
    .LONG_WAIT_CYC (LONGW)
  ) dut (
    .SYS_clk   (clk),
    .SYS_reset (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference timing: accept -> LOAD, SETUP+1, E_PULSE+1, WAIT+1 cycles.
  function automatic int exp_latency(input logic rs, input logic [7:0] db);
    int w;
    w = (!rs && (db == 8'h01 || db == 8'h02 || db == 8'h03)) ? LONGW : CMDW;
    return 1 + (SET + 1) + (EPW + 1) + (w + 1);
  endfunction

  // Pin monitor: records E pulses and bus-wide invariant violations.
  pulse_t     pulses[$];
  pulse_t     cur_p;
  logic [8:0] hist[$];
  bit         prev_e = 1'b0;
  bit         acc_prev = 1'b0;
  int         rw_bad = 0;
  int         dup_acc = 0;
  int         acc_cnt = 0;

  always @(negedge clk) begin : mon
    logic [8:0] now_v;
    now_v = {bus.pin[14], bus.pin[11:4]};
    if (bus.pin[13] !== 1'b0) rw_bad++;
    if (acc_prev && bus.req_ready) dup_acc++;
    acc_prev = bus.req_ready && bus.req_valid;
    if (acc_prev) acc_cnt++;
    if (bus.pin[12] && !prev_e) begin
      cur_p.rs   = now_v[8];
      cur_p.db   = now_v[7:0];
      cur_p.rise = cyc;
      cur_p.ok   = 1'b1;
      for (int i = 0; i < SET && i < hist.size(); i++)
        if (hist[i] !== now_v) cur_p.ok = 1'b0;
    end else if (bus.pin[12] && (now_v !== {cur_p.rs, cur_p.db})) begin
      cur_p.ok = 1'b0;
    end
    if (!bus.pin[12] && prev_e) begin
      cur_p.width = cyc - cur_p.rise;
      pulses.push_back(cur_p);
    end
    prev_e = bus.pin[12];
    hist.push_front(now_v);
    if (hist.size() > SET) void'(hist.pop_back());
  end

  task automatic wait_init();
    bit done;
    int early;
    done  = 1'b0;
    early = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (bus.init_done) done = 1'b1;
      else if (bus.req_ready) early++;
    end
    check("init_done_seen", done, 1);
    check("ready_with_init_done", bus.req_ready, bus.init_done);
    check("ready_during_init", early, 0);
  endtask

  task automatic check_init(input int rel);
    logic [7:0] rom [6];
    int gap;
    rom = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    check("init_pulse_count", pulses.size(), 6);
    if (pulses.size() == 6) begin
      check("first_e_window", (pulses[0].rise - rel >= POR + 1) &&
                              (pulses[0].rise - rel <= POR + SET + 4), 1);
      for (int i = 0; i < 6; i++) begin
        check("init_db", pulses[i].db, rom[i]);
        check("init_rs", pulses[i].rs, 0);
        check("init_e_width", pulses[i].width, EPW);
        check("init_stable", pulses[i].ok, 1);
        if (i > 0) begin
          gap = pulses[i].rise - (pulses[i-1].rise + pulses[i-1].width);
          if (rom[i-1] == 8'h01) check("init_gap_long", gap >= LONGW + 1, 1);
          else                   check("init_gap_short", (gap >= CMDW + 1) && (gap <= LONGW), 1);
        end
      end
    end
    pulses.delete();
  endtask

  // Waits for an accept with the current request, then checks the resulting write.
  task automatic run_xfer(input logic rs_e, input logic [7:0] db_e, input bit keep,
                          output int acc, output int rdy);
    bit got;
    pulse_t p;
    got = 1'b0;
    acc = 0;
    rdy = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (bus.req_ready && bus.req_valid) begin
        got = 1'b1;
        acc = cyc + 1;
      end else begin
        @(negedge clk);
      end
    end
    check("accept_seen", got, 1);
    if (got) begin
      n_sent++;
      @(posedge clk);
      #1;
      if (!keep) bus.req_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
        @(negedge clk);
        if (bus.req_ready) got = 1'b1;
      end
      rdy = cyc;
      check("ready_return_latency", got ? (rdy - acc) : -1, exp_latency(rs_e, db_e));
      check("write_pulse_count", pulses.size(), 1);
      if (pulses.size() > 0) begin
        p = pulses.pop_front();
        check("write_rs", p.rs, rs_e);
        check("write_db", p.db, db_e);
        check("write_e_width", p.width, EPW);
        check("write_e_offset", p.rise - acc, SET + 2);
        check("write_stable", p.ok, 1);
      end
      pulses.delete();
    end
  endtask

  task automatic send(input logic rs_v, input logic [7:0] db_v, input bit keep,
                      output int acc, output int rdy);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_rs    = rs_v;
    bus.req_data  = db_v;
    run_xfer(rs_v, db_v, keep, acc, rdy);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         rel, a1, r1, a2, r2;
    logic       rs_t [5];
    logic [7:0] db_t [5];
    logic       rs_r;
    logic [7:0] db_r;
    bit         got;

    bus.req_valid = 1'b1;
    bus.req_rs    = 1'b1;
    bus.req_data  = 8'h41;
    repeat (5) begin
      @(negedge clk);
      check("rst_pin", bus.pin, 0);
      check("rst_ready", bus.req_ready, 0);
      check("rst_state", bus.state, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    rel = cyc;
    pulses.delete();

    // Held request is ignored during init and accepted on the first idle cycle.
    wait_init();
    check("no_accept_during_init", acc_cnt, 0);
    check_init(rel);
    run_xfer(1'b1, 8'h41, 1'b0, a1, r1);
    repeat (30) @(negedge clk);
    check("single_accept_held", acc_cnt, 1);
    check("no_extra_pulse", pulses.size(), 0);

    rs_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    db_t = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01};
    for (int i = 0; i < 5; i++) begin
      send(rs_t[i], db_t[i], 1'b0, a1, r1);
    end

    // Back-to-back: valid held high is taken on the first idle cycle.
    send(1'b0, 8'h06, 1'b1, a1, r1);
    run_xfer(1'b0, 8'h06, 1'b0, a2, r2);
    check("b2b_accept_cycle", a2 - r1, 1);

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rs_r = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       db_r = 8'($urandom_range(1, 3));
        1:       db_r = 8'h04;
        default: db_r = 8'($urandom_range(0, 255));
      endcase
      send(rs_r, db_r, 1'($urandom_range(0, 1)), a1, r1);
      bus.req_valid = 1'b0;
    end

    // Reset mid-strobe: E must drop asynchronously and init must rerun.
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_rs    = 1'b0;
    bus.req_data  = 8'h0C;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (bus.pin[12]) got = 1'b1;
    end
    check("e_high_before_reset", got, 1);
    n_sent++;
    #1;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    check("async_rst_e", bus.pin[12], 0);
    check("async_rst_pin", bus.pin, 0);
    check("async_rst_init_done", bus.init_done, 0);
    check("async_rst_state", bus.state, 0);
    check("async_rst_ready", bus.req_ready, 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rel = cyc;
    pulses.delete();
    wait_init();
    check_init(rel);
    send(1'b1, 8'h5A, 1'b0, a1, r1);

    check("rw_always_zero", rw_bad, 0);
    check("one_accept_per_idle", dup_acc, 0);
    check("accept_count", acc_cnt, n_sent);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
